usb_tx_arbiter: RTL

//  Shares the single SIE transmit interface (txReqSendPacket/txDataValid/txIsLastByte/txData/txAcceptNewData)

---
 rtl/usb_tx_arb_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/usb_tx_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/usb_tx_arb_pkg.sv
// Shared types for the USB SIE transmit arbiter.
// Imported by the arbiter top and its round-robin picker.
package usb_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } arb_state_t;

  localparam int IPG_CYCLES_DEF = 8;
  localparam int IPG_CNT_W = $clog2(IPG_CYCLES_DEF + 1);

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational cyclic priority picker: first set request
// at or after the pointer, as one-hot and as an index.
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IW-1:0]      winner_idx,
  output logic               found
);

  always_comb begin : pick
    int c;
    logic [IW-1:0] ci;
    c = 0;
    ci = '0;
    winner = '0;
    winner_idx = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = (int'(ptr) + i) % NUM_REQ;
      ci = IW'(c);
      if (!found && req[ci]) begin
        found = 1'b1;
        winner[ci] = 1'b1;
        winner_idx = ci;
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the SIE transmit
// port between protocol-engine sources, with inter-packet gap.
module usb_tx_arbiter
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IPG_CYCLES = IPG_CYCLES_DEF
) (
  input  logic                    clk48,
  input  logic                    rst_n,
  input  logic                    rxBusy,
  input  logic [NUM_REQ-1:0]      reqSendPacket,
  input  logic [NUM_REQ-1:0]      reqDataValid,
  input  logic [NUM_REQ-1:0]      reqIsLastByte,
  input  logic [NUM_REQ-1:0][7:0] reqData,
  output logic [NUM_REQ-1:0]      reqAcceptNewData,
  output logic [NUM_REQ-1:0]      reqGrant,
  output logic                    txReqSendPacket,
  output logic                    txDataValid,
  output logic                    txIsLastByte,
  output logic [7:0]              txData,
  input  logic                    txAcceptNewData
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(IPG_CYCLES + 1);

  arb_state_t state;
  arb_state_t state_nx;

  logic [IW-1:0]      ptr;
  logic [CW-1:0]      gap_cnt;
  logic [NUM_REQ-1:0] win;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               start;
  logic               last_hs;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (reqSendPacket),
    .ptr       (ptr),
    .winner    (win),
    .winner_idx(win_idx),
    .found     (win_any)
  );

  assign start = !rxBusy && win_any;
  assign last_hs = txDataValid && txAcceptNewData && txIsLastByte;

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = SEND;
      SEND: if (last_hs) state_nx = GAP;
      GAP:  if (gap_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant is held for the whole packet regardless of reqSendPacket.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      reqGrant <= '0;
      ptr <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            reqGrant <= win;
            ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0
                 : win_idx + 1'b1;
          end
        end
        SEND: begin
          if (last_hs) begin
            reqGrant <= '0;
            gap_cnt <= CW'(IPG_CYCLES - 1);
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    txReqSendPacket = 1'b0;
    txDataValid = 1'b0;
    txIsLastByte = 1'b0;
    txData = '0;
    reqAcceptNewData = '0;
    if (state == SEND) begin
      txReqSendPacket = 1'b1;
      txDataValid = |(reqDataValid & reqGrant);
      txIsLastByte = |(reqIsLastByte & reqGrant);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (reqGrant[i]) txData = reqData[i];
      end
      reqAcceptNewData = reqGrant & {NUM_REQ{txAcceptNewData}};
    end
  end

endmodule
